// File: rtl/config_pkg.sv
// rtl/config_pkg.sv - MMU sizing constants shared by the instruction and data TLBs
package config_pkg;
  localparam int ITLB_ENTRIES = 8;
  localparam int DTLB_ENTRIES = 8;
endpackage

// File: rtl/tlb_plru.sv
// rtl/tlb_plru.sv - tree pseudo-LRU state for a fully associative TLB
// Heap-ordered node bits: node 0 is the root, children of n are 2n+1 and 2n+2.
module tlb_plru #(
  parameter int TLB_ENTRIES = 8,
  parameter int IDX_BITS    = $clog2(TLB_ENTRIES)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                touch_valid,
  input  logic [IDX_BITS-1:0] touch_idx,
  output logic [IDX_BITS-1:0] victim_idx
);

  logic [TLB_ENTRIES-2:0] plru_q, plru_d;
  logic [IDX_BITS-1:0]    upd_node, vic_node, vic;

  // A node bit of 0 sends the victim towards the lower-index subtree.
  always_comb begin
    plru_d   = plru_q;
    upd_node = '0;
    if (touch_valid) begin
      for (int l = 0; l < IDX_BITS; l++) begin
        upd_node         = IDX_BITS'((1 << l) - 1) + (touch_idx >> (IDX_BITS - l));
        plru_d[upd_node] = ~touch_idx[IDX_BITS-1-l];
      end
    end
    if (flush) plru_d = '0;
  end

  always_comb begin
    vic      = '0;
    vic_node = '0;
    for (int l = 0; l < IDX_BITS; l++) begin
      vic_node             = IDX_BITS'((1 << l) - 1) + (vic >> (IDX_BITS - l));
      vic[IDX_BITS-1-l]    = plru_q[vic_node];
    end
  end

  assign victim_idx = vic;

  always_ff @(posedge clk) begin
    if (reset) plru_q <= '0;
    else       plru_q <= plru_d;
  end

endmodule

// File: rtl/tlb_write_ctrl.sv
// rtl/tlb_write_ctrl.sv - fill/flush sequencer for a CAM-based fully associative TLB
// Victim is the lowest invalid entry, else the tree-PLRU choice.
module tlb_write_ctrl
  import config_pkg::*;
#(
  parameter int TLB_ENTRIES = DTLB_ENTRIES,
  parameter int IDX_BITS    = $clog2(TLB_ENTRIES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [TLB_ENTRIES-1:0] Matches,
  input  logic                   AccessValid,
  input  logic                   FillValid,
  output logic                   FillReady,
  input  logic                   FlushReq,
  output logic [TLB_ENTRIES-1:0] WriteEnables,
  output logic [IDX_BITS-1:0]    VictimIdx,
  output logic                   TLBFlush,
  output logic                   FillDone,
  output logic                   Busy
);

  typedef enum logic [1:0] {IDLE, WRITE, FLUSH} state_e;

  state_e                 state_q, state_d;
  logic [TLB_ENTRIES-1:0] valid_q, valid_d;
  logic                   flush_pend_q, flush_pend_d;
  logic [IDX_BITS-1:0]    victim_q, victim_d;
  logic [IDX_BITS-1:0]    plru_victim, victim_sel, touch_idx;
  logic                   touch_valid;

  function automatic logic [IDX_BITS-1:0] lowest_set(input logic [TLB_ENTRIES-1:0] v);
    lowest_set = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--)
      if (v[i]) lowest_set = IDX_BITS'(i);
  endfunction

  function automatic logic [TLB_ENTRIES-1:0] onehot(input logic [IDX_BITS-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  assign victim_sel  = (&valid_q) ? plru_victim : lowest_set(~valid_q);
  // The write's own touch takes precedence over a concurrent lookup hit.
  assign touch_valid = (state_q == WRITE) | (AccessValid & (|Matches));
  assign touch_idx   = (state_q == WRITE) ? victim_q : lowest_set(Matches);
  assign Busy        = (state_q != IDLE) | flush_pend_q;

  tlb_plru #(
    .TLB_ENTRIES(TLB_ENTRIES),
    .IDX_BITS   (IDX_BITS)
  ) u_plru (
    .clk        (clk),
    .reset      (reset),
    .flush      (state_q == FLUSH),
    .touch_valid(touch_valid),
    .touch_idx  (touch_idx),
    .victim_idx (plru_victim)
  );

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    flush_pend_d = flush_pend_q;
    victim_d     = victim_q;
    FillReady    = 1'b0;
    WriteEnables = '0;
    VictimIdx    = '0;
    TLBFlush     = 1'b0;
    FillDone     = 1'b0;
    case (state_q)
      IDLE: begin
        FillReady = ~FlushReq & ~flush_pend_q;
        if (FlushReq | flush_pend_q) begin
          state_d = FLUSH;
        end else if (FillValid) begin
          victim_d = victim_sel;
          state_d  = WRITE;
        end
      end
      WRITE: begin
        WriteEnables      = onehot(victim_q);
        VictimIdx         = victim_q;
        FillDone          = 1'b1;
        valid_d[victim_q] = 1'b1;
        flush_pend_d      = flush_pend_q | FlushReq;
        state_d           = (FlushReq | flush_pend_q) ? FLUSH : IDLE;
      end
      FLUSH: begin
        TLBFlush     = 1'b1;
        valid_d      = '0;
        flush_pend_d = FlushReq;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      flush_pend_q <= 1'b0;
      victim_q     <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      flush_pend_q <= flush_pend_d;
      victim_q     <= victim_d;
    end
  end

endmodule

// File: tb/tb_tlb_write_ctrl.sv
// tb/tb_tlb_write_ctrl.sv - directed and randomized bench for tlb_write_ctrl
// Reference PLRU: each tree level steers away from the half holding the most recent touch.
module tb_tlb_write_ctrl;
  localparam int N  = 8;
  localparam int IB = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  Matches = '0;
  logic          AccessValid = 1'b0, FillValid = 1'b0, FlushReq = 1'b0;
  logic          FillReady, TLBFlush, FillDone, Busy;
  logic [N-1:0]  WriteEnables;
  logic [IB-1:0] VictimIdx;

  always #5 clk = ~clk;

  tlb_write_ctrl #(.TLB_ENTRIES(N)) dut (
    .clk(clk), .reset(reset), .Matches(Matches), .AccessValid(AccessValid),
    .FillValid(FillValid), .FillReady(FillReady), .FlushReq(FlushReq),
    .WriteEnables(WriteEnables), .VictimIdx(VictimIdx), .TLBFlush(TLBFlush),
    .FillDone(FillDone), .Busy(Busy)
  );

  bit          m_valid [N];
  int unsigned m_ts    [N];
  int unsigned m_time;
  bit          m_write, m_flush, m_pend;
  int          m_widx;
  int          n_vec = 0, n_err = 0;
  logic [N-1:0]  o_we;
  logic [IB-1:0] o_vidx;
  logic          o_ready, o_flush, o_busy;
  bit            last_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < N; i++) begin m_valid[i] = 0; m_ts[i] = 0; end
  endfunction

  function automatic int model_victim();
    int lo, size, half;
    int unsigned lmax, rmax;
    for (int i = 0; i < N; i++) if (!m_valid[i]) return i;
    lo = 0; size = N;
    while (size > 1) begin
      half = size / 2; lmax = 0; rmax = 0;
      for (int i = lo; i < lo + half; i++) if (m_ts[i] > lmax) lmax = m_ts[i];
      for (int i = lo + half; i < lo + size; i++) if (m_ts[i] > rmax) rmax = m_ts[i];
      if (lmax > rmax) lo += half;
      size = half;
    end
    return lo;
  endfunction

  task automatic cycle();
    bit idle, exp_ready, was_write, was_flush, nw, nf;
    int v, nidx;
    @(negedge clk);
    idle      = !m_write && !m_flush;
    exp_ready = idle && !FlushReq && !m_pend;
    o_we = WriteEnables; o_vidx = VictimIdx; o_ready = FillReady;
    o_flush = TLBFlush; o_busy = Busy;
    chk("FillReady",    32'(FillReady),    32'(exp_ready));
    chk("WriteEnables", 32'(WriteEnables), m_write ? (32'd1 << m_widx) : 32'd0);
    chk("VictimIdx",    32'(VictimIdx),    m_write ? 32'(m_widx) : 32'd0);
    chk("FillDone",     32'(FillDone),     32'(m_write));
    chk("TLBFlush",     32'(TLBFlush),     32'(m_flush));
    chk("Busy",         32'(Busy),         32'(!idle || m_pend));
    v = model_victim();
    was_write = m_write; was_flush = m_flush;
    nw = 0; nf = 0; nidx = 0;
    last_acc = !reset && idle && FillValid && exp_ready && !(FlushReq || m_pend);
    if (reset) begin
      model_clear(); m_pend = 0;
    end else begin
      if (was_flush) model_clear();
      else if (was_write) begin
        m_time++; m_ts[m_widx] = m_time; m_valid[m_widx] = 1;
      end else if (AccessValid && Matches != 0) begin
        for (int i = N - 1; i >= 0; i--) if (Matches[i]) nidx = i;
        m_time++; m_ts[nidx] = m_time;
      end
      if (idle) begin
        if (FlushReq || m_pend) nf = 1;
        else if (FillValid) begin nw = 1; nidx = v; end
      end else if (was_write) begin
        nf = FlushReq || m_pend; m_pend = m_pend || FlushReq;
      end else begin
        m_pend = FlushReq;
      end
    end
    m_write = nw; m_flush = nf; m_widx = nidx;
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input string tag, input logic [N-1:0] exp_we);
    bit got = 0;
    FillValid = 1'b1;
    for (int k = 0; k < 6 && !got; k++) begin cycle(); got = last_acc; end
    chk({tag, "_accepted"}, 32'(got), 32'd1);
    cycle();
    chk({tag, "_we"}, 32'(o_we), 32'(exp_we));
    FillValid = 1'b0;
  endtask

  initial begin
    model_clear(); m_time = 0; m_write = 0; m_flush = 0; m_pend = 0; m_widx = 0;
    cycle(); cycle();
    reset = 1'b0;
    cycle();
    chk("reset_ready", 32'(o_ready), 32'd1);
    chk("reset_busy",  32'(o_busy),  32'd0);

    for (int i = 0; i < N; i++) fill($sformatf("fill%0d", i), N'(1) << i);
    fill("ninth", 8'h01);
    AccessValid = 1'b1; Matches = 8'h01; cycle();
    AccessValid = 1'b0; Matches = '0;
    fill("after_access", 8'h10);

    FlushReq = 1'b1; cycle(); FlushReq = 1'b0;
    cycle();
    chk("flush_strobe", 32'(o_flush), 32'd1);
    chk("flush_ready",  32'(o_ready), 32'd0);
    cycle();
    chk("flush_single", 32'(o_flush), 32'd0);
    fill("after_flush", 8'h01);

    FlushReq = 1'b1; FillValid = 1'b1; cycle();
    chk("flush_fill_ready", 32'(o_ready), 32'd0);
    FlushReq = 1'b0; cycle();
    chk("flush_fill_flush", 32'(o_flush), 32'd1);
    cycle();
    chk("flush_fill_acc", 32'(last_acc), 32'd1);
    FillValid = 1'b0; cycle();
    chk("flush_fill_we", 32'(o_we), 32'h01);

    FillValid = 1'b1; cycle(); FillValid = 1'b0;
    FlushReq = 1'b1; cycle(); FlushReq = 1'b0;
    chk("wflush_busy_w", 32'(o_busy), 32'd1);
    chk("wflush_we",     32'(o_we),   32'h02);
    cycle();
    chk("wflush_flush",  32'(o_flush), 32'd1);
    chk("wflush_busy_f", 32'(o_busy),  32'd1);

    for (int i = 0; i < N; i++) fill($sformatf("refill%0d", i), N'(1) << i);
    AccessValid = 1'b1; Matches = 8'hFF; cycle();
    AccessValid = 1'b0; Matches = '0;
    FillValid = 1'b1; cycle(); FillValid = 1'b0;
    reset = 1'b1; cycle(); reset = 1'b0;
    chk("multihit_victim", 32'(o_vidx), 32'd4);
    cycle();
    chk("post_reset_we", 32'(o_we), 32'd0);
    fill("post_reset_fill", 8'h01);

    for (int c = 0; c < 3000; c++) begin
      reset       = ($urandom_range(0, 299) == 0);
      FlushReq    = ($urandom_range(0, 39) == 0);
      FillValid   = $urandom_range(0, 1);
      AccessValid = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0:       Matches = '0;
        1:       Matches = N'($urandom);
        default: Matches = N'(1) << $urandom_range(0, N - 1);
      endcase
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
